// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_prog.
// The FIFO is the slave side; whoever drives writes/reads uses master.
interface sync_fifo_prog_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
);
  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic [CNT_W-1:0]  i_af_thresh;
  logic [CNT_W-1:0]  i_ae_thresh;
  logic              i_clr_err;
  logic [DATA_W-1:0] o_rddata;
  logic              o_full;
  logic              o_alm_full;
  logic              o_alm_empty;
  logic              o_empty;
  logic [CNT_W-1:0]  o_count;
  logic              o_overflow;
  logic              o_underflow;

  modport slave (
    input  i_wren, i_wrdata, i_rden, i_af_thresh, i_ae_thresh, i_clr_err,
    output o_rddata, o_full, o_alm_full, o_alm_empty, o_empty, o_count,
           o_overflow, o_underflow
  );

  modport master (
    output i_wren, i_wrdata, i_rden, i_af_thresh, i_ae_thresh, i_clr_err,
    input  o_rddata, o_full, o_alm_full, o_alm_empty, o_empty, o_count,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with live-programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and optional FWFT read.
// Level flags are derived from the registered count, so they move one cycle
// after the accepting edge; thresholds are compared without registering.
module sync_fifo_prog #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int FWFT   = 0,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             rstn,
  sync_fifo_prog_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  // At full only the read can be accepted, so count never passes DEPTH.
  assign w_wr_acc = bus.i_wren && !w_full;
  assign w_rd_acc = bus.i_rden && !w_empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.i_wrdata;
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
    end
  end

  // Occupancy: holds when both or neither side is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.i_wren && w_full)     r_overflow <= 1'b1;
      else if (bus.i_clr_err)       r_overflow <= 1'b0;
      if (bus.i_rden && w_empty)    r_underflow <= 1'b1;
      else if (bus.i_clr_err)       r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is exposed directly; meaningless while empty.
      assign bus.o_rddata = r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [DATA_W-1:0] r_rddata;
      // Registered read port, loaded only on an accepted read.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         r_rddata <= '0;
        else if (w_rd_acc) r_rddata <= r_mem[r_rd_ptr];
      end
      assign bus.o_rddata = r_rddata;
    end
  endgenerate

  // A zero af threshold and an ae threshold >= DEPTH fall out of the compares.
  assign bus.o_full      = w_full;
  assign bus.o_empty     = w_empty;
  assign bus.o_alm_full  = (r_count >= bus.i_af_thresh);
  assign bus.o_alm_empty = (r_count <= bus.i_ae_thresh);
  assign bus.o_count     = r_count;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_underflow = r_underflow;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: one registered-read instance (DEPTH=8) driven by
// a vector table plus hand sequences, and one FWFT instance.
module tb_sync_fifo_prog;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DATA_W(8), .DEPTH(8)) bus1 ();
  sync_fifo_prog_if #(.DATA_W(8), .DEPTH(8)) bus2 ();

  sync_fifo_prog #(.DATA_W(8), .DEPTH(8), .FWFT(0)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
  sync_fifo_prog #(.DATA_W(8), .DEPTH(8), .FWFT(1)) dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

  typedef struct {
    logic       wren;
    logic [7:0] wd;
    logic       rden;
    logic       clr;
    int         cnt;
    logic       full, af, ae, empty, ovf, unf;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb[$];
  int m_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock on dut1; the scoreboard predicts read data from its own count.
  task automatic cyc(input logic wren, input logic [7:0] wd, input logic rden, input logic clr);
    logic wacc, racc;
    logic [7:0] exp_rd;
    exp_rd = 8'h00;
    bus1.i_wren = wren; bus1.i_wrdata = wd; bus1.i_rden = rden; bus1.i_clr_err = clr;
    wacc = wren && (m_cnt < 8);
    racc = rden && (m_cnt > 0);
    if (racc) exp_rd = sb.pop_front();
    if (wacc) sb.push_back(wd);
    m_cnt = m_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    @(posedge clk); #1;
    bus1.i_wren = 1'b0; bus1.i_rden = 1'b0; bus1.i_clr_err = 1'b0;
    if (racc) check("rddata", int'(bus1.o_rddata), int'(exp_rd));
  endtask

  function automatic vec_t mk(input logic wren, input logic [7:0] wd, input logic rden,
                              input logic clr, input int cnt, input logic full, input logic af,
                              input logic ae, input logic empty, input logic ovf, input logic unf);
    vec_t v;
    v.wren = wren; v.wd = wd; v.rden = rden; v.clr = clr; v.cnt = cnt;
    v.full = full; v.af = af; v.ae = ae; v.empty = empty; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    sb.delete();
    m_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    vec_t tbl[$];

    // Tests 1-3: fill, overflow, drain in order, clear, underflow, clr-vs-set.
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1'b1, 8'h10 + 8'(k - 1), 1'b0, 1'b0, k, k == 8, k >= 6, k <= 1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 7; k >= 0; k--)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, k, 1'b0, k >= 6, k <= 1, k == 0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));

    bus1.i_wren = 1'b0; bus1.i_wrdata = 8'h00; bus1.i_rden = 1'b0; bus1.i_clr_err = 1'b0;
    bus1.i_af_thresh = 4'd6; bus1.i_ae_thresh = 4'd1;
    bus2.i_wren = 1'b0; bus2.i_wrdata = 8'h00; bus2.i_rden = 1'b0; bus2.i_clr_err = 1'b0;
    bus2.i_af_thresh = 4'd6; bus2.i_ae_thresh = 4'd1;
    do_reset();

    // Reset state.
    check("rst_count", int'(bus1.o_count), 0);
    check("rst_empty", int'(bus1.o_empty), 1);
    check("rst_full", int'(bus1.o_full), 0);
    check("rst_afull", int'(bus1.o_alm_full), 0);
    check("rst_aempty", int'(bus1.o_alm_empty), 1);
    check("rst_ovf", int'(bus1.o_overflow), 0);
    check("rst_unf", int'(bus1.o_underflow), 0);
    check("rst_rddata", int'(bus1.o_rddata), 0);

    // Live threshold: af=0 forces almost-full even when empty.
    bus1.i_af_thresh = 4'd0; #1;
    check("af0_afull", int'(bus1.o_alm_full), 1);
    bus1.i_af_thresh = 4'd6; #1;
    check("af6_afull", int'(bus1.o_alm_full), 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].wren, tbl[i].wd, tbl[i].rden, tbl[i].clr);
      check($sformatf("v%0d_count", i), int'(bus1.o_count), tbl[i].cnt);
      check($sformatf("v%0d_full", i), int'(bus1.o_full), int'(tbl[i].full));
      check($sformatf("v%0d_afull", i), int'(bus1.o_alm_full), int'(tbl[i].af));
      check($sformatf("v%0d_aempty", i), int'(bus1.o_alm_empty), int'(tbl[i].ae));
      check($sformatf("v%0d_empty", i), int'(bus1.o_empty), int'(tbl[i].empty));
      check($sformatf("v%0d_ovf", i), int'(bus1.o_overflow), int'(tbl[i].ovf));
      check($sformatf("v%0d_unf", i), int'(bus1.o_underflow), int'(tbl[i].unf));
    end
    // Rejected reads left the last popped word on the port.
    check("unf_rddata_hold", int'(bus1.o_rddata), 8'h17);

    // Test 4: count 4, simultaneous read/write for 20 cycles, pointers wrap.
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'h20 + 8'(k), 1'b0, 1'b0);
    check("t4_count_pre", int'(bus1.o_count), 4);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 8'h24 + 8'(k), 1'b1, 1'b0);
      check("t4_count", int'(bus1.o_count), 4);
    end
    // Live threshold: ae >= DEPTH forces almost-empty at any count.
    bus1.i_ae_thresh = 4'd8; #1;
    check("ae8_aempty", int'(bus1.o_alm_empty), 1);
    bus1.i_ae_thresh = 4'd1; #1;
    check("ae1_aempty", int'(bus1.o_alm_empty), 0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_empty", int'(bus1.o_empty), 1);

    // Test 5: FWFT instance.
    bus2.i_wren = 1'b1; bus2.i_wrdata = 8'h5A;
    @(posedge clk); #1;
    bus2.i_wrdata = 8'h5B;
    check("fwft_empty0", int'(bus2.o_empty), 0);
    check("fwft_data0", int'(bus2.o_rddata), 8'h5A);
    @(posedge clk); #1;
    bus2.i_wren = 1'b0;
    check("fwft_head_kept", int'(bus2.o_rddata), 8'h5A);
    bus2.i_rden = 1'b1;
    @(posedge clk); #1;
    check("fwft_data1", int'(bus2.o_rddata), 8'h5B);
    check("fwft_count1", int'(bus2.o_count), 1);
    @(posedge clk); #1;
    bus2.i_rden = 1'b0;
    check("fwft_empty1", int'(bus2.o_empty), 1);

    // Test 6: underflow, fill to 5, then asynchronous reset mid-burst.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_unf_set", int'(bus1.o_underflow), 1);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'h60 + 8'(k), 1'b0, 1'b0);
    check("t6_count5", int'(bus1.o_count), 5);
    bus1.i_wren = 1'b1; bus1.i_wrdata = 8'h66;
    #3 rstn = 1'b0;
    #1;
    check("t6_async_count", int'(bus1.o_count), 0);
    check("t6_async_empty", int'(bus1.o_empty), 1);
    check("t6_async_unf", int'(bus1.o_underflow), 0);
    check("t6_async_ovf", int'(bus1.o_overflow), 0);
    bus1.i_wren = 1'b0;
    do_reset();
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    check("t6_count_new", int'(bus1.o_count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_empty_end", int'(bus1.o_empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
